ram_responder: RTL and testbench

//  Memory-side end of the datapath MOV/MOC handshake. Sits opposite the MAR/MDR datapath.

---
 rtl/ram_responder_if.sv | 27 ++
 rtl/ram_responder.sv | 146 ++++++++++++++
 tb/tb_ram_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// MOV/MOC request/complete bundle between the MAR/MDR datapath (master)
// and the memory responder (slave).
interface ram_responder_if #(
  parameter int unsigned ADDR_W = 9
);
  // Handshake: master raises MOV with RW/Type/Addr/DataIn stable and holds MOV
  // until MOC is seen; slave raises MOC (DataOut/Err valid) and holds it until
  // MOV drops, then lowers MOC on the next edge. MOV must stay low >= 1 cycle.
  logic              MOV;
  logic              RW;
  logic [1:0]        Type;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              Err;

  modport master (
    output MOV, RW, Type, Addr, DataIn,
    input  DataOut, MOC, Err
  );

  modport slave (
    input  MOV, RW, Type, Addr, DataIn,
    output DataOut, MOC, Err
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side MOV/MOC responder: wait states, then big-endian byte/half/word
// access to an internal byte RAM. Optional macro ALIGN_CHECK_EN flags misaligned ops.
module ram_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Clr_n,
  ram_responder_if.slave   bus,
  output logic [1:0]       state_dbg
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              req_rw;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              moc_q;
  logic              err_q;
  logic [31:0]       dout_q;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              bad;
  logic [31:0]       rd_data;

  assign bus.MOC     = moc_q;
  assign bus.Err     = err_q;
  assign bus.DataOut = dout_q;
  assign state_dbg   = state_q;

  // Base address and error decode from the latched request only.
  always_comb begin
    a0  = req_addr;
    bad = (req_type == 2'b11);
`ifdef ALIGN_CHECK_EN
    if (req_type == 2'b01 && req_addr[0])          bad = 1'b1;
    if (req_type == 2'b10 && req_addr[1:0] != 2'b00) bad = 1'b1;
`else
    if (req_type == 2'b01)      a0[0]   = 1'b0;
    else if (req_type == 2'b10) a0[1:0] = 2'b00;
`endif
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

  always_comb begin
    rd_data = 32'h0;
    case (req_type)
      2'b00:   rd_data = {24'h0, mem[a0]};
      2'b01:   rd_data = {16'h0, mem[a0], mem[a1]};
      2'b10:   rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.MOV) state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.MOV)          state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   if (!bus.MOV) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      req_rw   <= 1'b0;
      req_type <= 2'b00;
      req_addr <= '0;
      req_data <= 32'h0;
      moc_q    <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.MOV) begin
            req_rw   <= bus.RW;
            req_type <= bus.Type;
            req_addr <= bus.Addr;
            req_data <= bus.DataIn;
            cnt_q    <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (bus.MOV && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          moc_q <= 1'b1;
          err_q <= bad;
          if (bad)         dout_q <= 32'h0;
          else if (req_rw) dout_q <= rd_data;
        end
        S_DONE: begin
          if (!bus.MOV) begin
            moc_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately not reset; a write lands only on the ACCESS edge.
  always_ff @(posedge Clk) begin
    if (state_q == S_ACCESS && !req_rw && !bad) begin
      case (req_type)
        2'b00: mem[a0] <= req_data[7:0];
        2'b01: begin
          mem[a0] <= req_data[15:8];
          mem[a1] <= req_data[7:0];
        end
        2'b10: begin
          mem[a0] <= req_data[31:24];
          mem[a1] <= req_data[23:16];
          mem[a2] <= req_data[15:8];
          mem[a3] <= req_data[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: latency, endianness, abort, reset,
// alignment (follows ALIGN_CHECK_EN if defined) and reserved type.
module tb_ram_responder;

  localparam int unsigned ADDR_W = 9;
  localparam int          LAT    = 4;  // WAIT_CYCLES(2) + 2

  logic        clk;
  logic        clr_n;
  logic [1:0]  state_dbg;
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut (
    .Clk       (clk),
    .Clr_n     (clr_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full MOV/MOC transaction; inputs are scrambled after acceptance.
  task automatic op(input logic rw, input logic [1:0] ty, input logic [8:0] addr,
                    input logic [31:0] din, input int hold,
                    output logic [31:0] dout, output logic err, output int lat);
    @(negedge clk);
    bus.RW = rw; bus.Type = ty; bus.Addr = addr; bus.DataIn = din; bus.MOV = 1'b1;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        bus.Addr = ~addr; bus.DataIn = ~din; bus.RW = ~rw; bus.Type = ~ty;
      end
      if (bus.MOC) begin
        lat = n;
        break;
      end
    end
    dout = bus.DataOut;
    err  = bus.Err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("moc_hold", {31'h0, bus.MOC}, 32'h1);
    end
    bus.MOV = 1'b0;
    @(posedge clk); #1;
    check("moc_fall", {31'h0, bus.MOC}, 32'h0);
    check("err_fall", {31'h0, bus.Err}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] ty, input logic [8:0] addr, input logic [31:0] din,
                    input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    int          l;
    op(1'b0, ty, addr, din, 0, d, e, l);
    check({tag, "_lat"}, l, LAT);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  task automatic rd(input logic [1:0] ty, input logic [8:0] addr, input logic [31:0] expv,
                    input logic exp_err, input int hold, input string tag);
    logic [31:0] d;
    logic        e;
    int          l;
    exp_q.push_back(expv);
    op(1'b1, ty, addr, 32'h0, hold, d, e, l);
    check({tag, "_lat"}, l, LAT);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
    check(tag, d, exp_q.pop_front());
  endtask

  initial begin
    logic seen;
    n_cmp = 0; n_err = 0;
    clr_n = 1'b0;
    bus.MOV = 1'b0; bus.RW = 1'b0; bus.Type = 2'b00; bus.Addr = '0; bus.DataIn = '0;
    repeat (3) @(negedge clk);
    check("rst_moc",   {31'h0, bus.MOC}, 32'h0);
    check("rst_err",   {31'h0, bus.Err}, 32'h0);
    check("rst_dout",  bus.DataOut, 32'h0);
    check("rst_state", {30'h0, state_dbg}, 32'h0);
    clr_n = 1'b1;

    // basic word write/read, latency and hold
    wr(2'b10, 9'h010, 32'hDEADBEEF, 1'b0, "wr_w010");
    rd(2'b10, 9'h010, 32'hDEADBEEF, 1'b0, 3, "rd_w010");
    rd(2'b00, 9'h011, 32'h000000AD, 1'b0, 0, "rd_b011");
    rd(2'b01, 9'h012, 32'h0000BEEF, 1'b0, 0, "rd_h012");
    rd(2'b00, 9'h013, 32'h000000EF, 1'b0, 0, "rd_b013");

    // abort during WAIT
    wr(2'b10, 9'h020, 32'h0BADF00D, 1'b0, "wr_w020");
    @(negedge clk);
    bus.RW = 1'b0; bus.Type = 2'b10; bus.Addr = 9'h020; bus.DataIn = 32'h12345678; bus.MOV = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.MOV = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.MOC;
    end
    check("abort_moc",   {31'h0, seen}, 32'h0);
    check("abort_state", {30'h0, state_dbg}, 32'h0);
    rd(2'b10, 9'h020, 32'h0BADF00D, 1'b0, 0, "rd_abort");

    // reset asserted in WAIT of a write
    @(negedge clk);
    bus.RW = 1'b0; bus.Type = 2'b10; bus.Addr = 9'h010; bus.DataIn = 32'h11111111; bus.MOV = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    check("midrst_moc",   {31'h0, bus.MOC}, 32'h0);
    check("midrst_dout",  bus.DataOut, 32'h0);
    check("midrst_state", {30'h0, state_dbg}, 32'h0);
    bus.MOV = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    rd(2'b10, 9'h010, 32'hDEADBEEF, 1'b0, 0, "rd_after_rst");

    // partial writes leave neighbouring bytes intact
    wr(2'b10, 9'h040, 32'h11223344, 1'b0, "wr_w040");
    wr(2'b00, 9'h042, 32'hFFFFFFAA, 1'b0, "wr_b042");
    rd(2'b10, 9'h040, 32'h1122AA44, 1'b0, 0, "rd_w040a");
    wr(2'b01, 9'h040, 32'hFFFF5566, 1'b0, "wr_h040");
    rd(2'b10, 9'h040, 32'h5566AA44, 1'b0, 0, "rd_w040b");

    // top of address space
    wr(2'b10, 9'h1FC, 32'h01020304, 1'b0, "wr_w1fc");
    rd(2'b00, 9'h1FF, 32'h00000004, 1'b0, 0, "rd_b1ff");
    wr(2'b00, 9'h1FF, 32'h0000005A, 1'b0, "wr_b1ff");
    rd(2'b10, 9'h1FC, 32'h0102035A, 1'b0, 0, "rd_w1fc");

    // misaligned word write
`ifdef ALIGN_CHECK_EN
    wr(2'b10, 9'h012, 32'hCAFEF00D, 1'b1, "wr_mis");
    rd(2'b10, 9'h010, 32'hDEADBEEF, 1'b0, 0, "rd_mis");
    rd(2'b01, 9'h011, 32'h00000000, 1'b1, 0, "rd_mis_h");
`else
    wr(2'b10, 9'h012, 32'hCAFEF00D, 1'b0, "wr_mis");
    rd(2'b10, 9'h010, 32'hCAFEF00D, 1'b0, 0, "rd_mis");
    rd(2'b01, 9'h011, 32'h0000CAFE, 1'b0, 0, "rd_mis_h");
`endif

    // reserved type
    wr(2'b11, 9'h010, 32'hFFFFFFFF, 1'b1, "wr_rsv");
    rd(2'b11, 9'h010, 32'h00000000, 1'b1, 0, "rd_rsv");
`ifdef ALIGN_CHECK_EN
    rd(2'b10, 9'h010, 32'hDEADBEEF, 1'b0, 0, "rd_after_rsv");
`else
    rd(2'b10, 9'h010, 32'hCAFEF00D, 1'b0, 0, "rd_after_rsv");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
